// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and helpers for the LFSR sequence generator
//
// Purpose : generator FSM state enum, Galois step function, and a table of
//           maximal-length Galois feedback masks for widths 3..16.
// Ports   : none (package).

package lfsr_pkg;

    // Widest LFSR supported; helpers operate on this width and callers
    // zero-extend their narrower state/taps.
    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    // Right-shifting Galois masks giving a period of 2^n - 1, indexed by width.
    localparam logic [MAX_WIDTH-1:0] MAX_TAPS [3:16] = '{
        16'h0006,   // 3
        16'h000C,   // 4
        16'h0014,   // 5
        16'h0030,   // 6
        16'h0060,   // 7
        16'h00B8,   // 8
        16'h0110,   // 9
        16'h0240,   // 10
        16'h0500,   // 11
        16'h0829,   // 12
        16'h100D,   // 13
        16'h2015,   // 14
        16'h6000,   // 15
        16'hD008    // 16
    };

    // One Galois step: shift right, fold the mask in when the bit shifted
    // out was set. A nonzero state never maps to zero.
    function automatic logic [MAX_WIDTH-1:0] galois_step(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps
    );
        return (state >> 1) ^ (state[0] ? taps : {MAX_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR state register with Galois step function
//
// Purpose : holds the LFSR state; loads a new state or advances one step.
// Ports   : clk, reset (async, active-high)
//           load        - replace state with load_value (wins over adv)
//           load_value  - state to load; caller guarantees nonzero
//           adv         - advance state to next
//           state       - current LFSR state
//           next        - combinational successor of state

module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(4'hC),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             adv,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    logic [MAX_WIDTH-1:0] state_ext;
    logic [MAX_WIDTH-1:0] taps_ext;
    logic [MAX_WIDTH-1:0] step_ext;
    // Upper bits of the widened step are always zero; folded here so the
    // full-width result is consumed.
    logic                 unused_step_hi;

    always_comb begin
        state_ext             = '0;
        taps_ext              = '0;
        state_ext[WIDTH-1:0]  = state;
        taps_ext[WIDTH-1:0]   = TAPS;
        step_ext              = galois_step(state_ext, taps_ext);
        next                  = step_ext[WIDTH-1:0];
        unused_step_hi        = ^step_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_VALUE;
        end else if (load) begin
            state <= load_value;
        end else if (adv) begin
            state <= next;
        end
    end

endmodule

// File: rtl/lfsr_sequence_gen.sv
// rtl/lfsr_sequence_gen.sv - Galois LFSR sequence generator with handshake
//
// Purpose : pseudo-random source with runtime seed, zero-seed protection,
//           free-run / one-shot modes, wrap detection and step counting,
//           presented through a valid/ready output with backpressure.
// Ports   : clk, reset (async, active-high)
//           seed_load, seed_in      - load runtime seed, clear counters/flags
//           enable                  - permit stepping
//           oneshot                 - stop after one full period
//           out_data, out_valid     - generated value and its valid flag
//           out_ready               - consumer accepts out_data
//           wrap                    - pulse: sequence returned to start value
//           step_cnt                - steps since start value
//           done                    - one-shot period complete (sticky)
//           lockup                  - pulse: zero seed replaced by 1

module lfsr_sequence_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'hC),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             enable,
    input  logic             oneshot,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt,
    output logic             done,
    output logic             lockup
);

    // A zero state would lock the LFSR, so zero seeds are replaced by 1.
    localparam logic [WIDTH-1:0] START_RST = (SEED == '0) ? WIDTH'(1) : SEED;

    gen_state_t       state;
    gen_state_t       state_next;

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] seed_fixed;
    logic             seed_zero;
    logic             stall;
    logic             adv;
    logic             wrap_hit;

    assign seed_zero  = (seed_in == '0);
    assign seed_fixed = seed_zero ? WIDTH'(1) : seed_in;

    // done is the DONE state itself, so it stays sticky until seed_load.
    assign done     = (state == DONE);
    assign stall    = out_valid & ~out_ready;
    assign adv      = enable & ~stall & ~done & ~seed_load;
    assign wrap_hit = (lfsr_next == start);

    lfsr_core #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .RESET_VALUE (START_RST)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (seed_load),
        .load_value (seed_fixed),
        .adv        (adv),
        .state      (lfsr),
        .next       (lfsr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE is left only through seed_load; the one-shot entry is taken on
    // the step that returns to the start value.
    always_comb begin
        state_next = state;
        if (seed_load) begin
            state_next = enable ? RUN : IDLE;
        end else if (state == DONE) begin
            state_next = DONE;
        end else if (adv && wrap_hit && oneshot) begin
            state_next = DONE;
        end else if (adv) begin
            state_next = RUN;
        end else if (enable && stall) begin
            state_next = HOLD;
        end else begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start     <= START_RST;
            out_data  <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            step_cnt  <= '0;
            lockup    <= 1'b0;
        end else if (seed_load) begin
            // Any unconsumed value is dropped here.
            start     <= seed_fixed;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            step_cnt  <= '0;
            lockup    <= seed_zero;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (adv) begin
                // Accept and advance together keeps out_valid high for
                // one value per cycle.
                out_data  <= lfsr_next;
                out_valid <= 1'b1;
                if (wrap_hit) begin
                    wrap     <= 1'b1;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + WIDTH'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_sequence_gen.sv
// tb/tb_lfsr_sequence_gen.sv - scoreboard testbench for lfsr_sequence_gen

module tb_lfsr_sequence_gen;

    typedef struct {
        logic [3:0] d;
        logic       w;
        logic [3:0] c;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       seed_load;
    logic [3:0] seed_in;
    logic       enable;
    logic       oneshot;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       wrap;
    logic [3:0] step_cnt;
    logic       done;
    logic       lockup;

    int   total;
    int   bad;
    exp_t q[$];

    logic [3:0] seq1 [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                              4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    logic [3:0] seq9 [15] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h6, 4'h3, 4'hD,
                              4'hA, 4'h5, 4'hE, 4'h7, 4'hF, 4'hB, 4'h9};

    lfsr_sequence_gen #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .SEED  (4'h1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .enable    (enable),
        .oneshot   (oneshot),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap),
        .step_cnt  (step_cnt),
        .done      (done),
        .lockup    (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic w, input logic [3:0] c);
        exp_t e;
        e.d = d;
        e.w = w;
        e.c = c;
        q.push_back(e);
    endtask

    // Whole period from a start value: counter climbs to 14, wrap on the last.
    task automatic push_period(input int which);
        for (int i = 0; i < 15; i++) begin
            push(which == 9 ? seq9[i] : seq1[i], i == 14, (i == 14) ? 4'd0 : 4'(i + 1));
        end
    endtask

    task automatic load_seed(input logic [3:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
    endtask

    // Monitor: every accepted value is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(out_data), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("step_cnt", 32'(step_cnt), 32'(e.c));
                chk("wrap", 32'(wrap), 32'(e.w));
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        seed_load = 1'b0;
        seed_in   = 4'h0;
        enable    = 1'b0;
        oneshot   = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_step_cnt", 32'(step_cnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lockup", 32'(lockup), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Free-run full period.
        push_period(1);
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("free_drained", q.size(), 0);
        chk("free_valid_low", 32'(out_valid), 0);
        chk("free_no_done", 32'(done), 0);

        // One-shot period, then blocked.
        load_seed(4'h1);
        oneshot = 1'b1;
        enable  = 1'b1;
        push_period(1);
        repeat (25) @(posedge clk);
        #1;
        chk("oneshot_drained", q.size(), 0);
        chk("oneshot_done", 32'(done), 1);
        chk("oneshot_valid_low", 32'(out_valid), 0);
        chk("oneshot_data_held", 32'(out_data), 1);
        enable  = 1'b0;
        oneshot = 1'b0;
        load_seed(4'h1);
        chk("seed_clears_done", 32'(done), 0);

        // Backpressure on the first value.
        out_ready = 1'b0;
        enable    = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_data", 32'(out_data), 4'hC);
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_cnt", 32'(step_cnt), 1);
        push(4'hC, 1'b0, 4'd1);
        push(4'h6, 1'b0, 4'd2);
        push(4'h3, 1'b0, 4'd3);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_drained", q.size(), 0);

        // Zero seed lockup, then seed 9 full period.
        seed_in   = 4'h0;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        chk("lockup_pulse", 32'(lockup), 1);
        chk("lockup_cnt", 32'(step_cnt), 0);
        seed_load = 1'b0;
        @(posedge clk);
        #1;
        chk("lockup_one_cycle", 32'(lockup), 0);
        push(4'hC, 1'b0, 4'd1);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        load_seed(4'h9);
        chk("seed9_no_lockup", 32'(lockup), 0);
        push_period(9);
        enable = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("seed9_drained", q.size(), 0);

        // seed_load while a value is pending drops it.
        load_seed(4'h1);
        out_ready = 1'b0;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        chk("pend_valid", 32'(out_valid), 1);
        seed_in   = 4'h5;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        chk("drop_valid", 32'(out_valid), 0);
        chk("drop_cnt", 32'(step_cnt), 0);
        push(4'hE, 1'b0, 4'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_drained", q.size(), 0);

        // Async reset mid-sequence, then restart.
        load_seed(4'h1);
        for (int i = 0; i < 7; i++) push(seq1[i], 1'b0, 4'(i + 1));
        enable = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_cnt", 32'(step_cnt), 0);
        chk("arst_drained", q.size(), 0);
        @(posedge clk);
        #1;
        push_period(1);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
